kugelblitz_pad_mask: RTL and testbench

KUGELBLITZ_PAD_MASK -- requirements
Module: kugelblitz_pad_mask

---
 rtl/kugelblitz_pad_mask.sv | 237 +++++++++++++++++++++++
 tb/tb_kugelblitz_pad_mask.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kugelblitz_pad_mask.sv
// AXI-Stream stage that zeroes unkept byte lanes and pads short frames with zero
// bytes up to MIN_FRAME_LEN, with forwarded/padded frame statistics.
module kugelblitz_pad_mask #(
    parameter int unsigned DATA_WIDTH    = 512,
    parameter int unsigned KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int unsigned USER_WIDTH    = 1,
    parameter int unsigned MIN_FRAME_LEN = 60,
    parameter int unsigned CNT_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    input  logic                  pad_enable,
    output logic [CNT_WIDTH-1:0]  frame_count,
    output logic [CNT_WIDTH-1:0]  pad_count
);

    localparam int unsigned BCW  = $clog2(MIN_FRAME_LEN + KEEP_WIDTH) + 1;
    localparam int unsigned SUMW = BCW + 1;
    localparam logic [BCW-1:0] MIN_B  = BCW'(MIN_FRAME_LEN);
    localparam logic [BCW-1:0] KEEP_B = BCW'(KEEP_WIDTH);
    localparam logic [BCW-1:0] SAT_B  = {BCW{1'b1}};

    if (!(DATA_WIDTH == 64 || DATA_WIDTH == 128 || DATA_WIDTH == 256 || DATA_WIDTH == 512)) begin : g_bad_data_width
        $error("kugelblitz_pad_mask: DATA_WIDTH must be 64, 128, 256 or 512");
    end
    if (KEEP_WIDTH * 8 != DATA_WIDTH) begin : g_bad_keep_width
        $error("kugelblitz_pad_mask: KEEP_WIDTH*8 must equal DATA_WIDTH");
    end
    if (MIN_FRAME_LEN < 1 || MIN_FRAME_LEN > 255) begin : g_bad_min_len
        $error("kugelblitz_pad_mask: MIN_FRAME_LEN must be within 1..255");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BODY = 2'd1,
        PAD  = 2'd2
    } state_e;

    function automatic logic [BCW-1:0] popcount(input logic [KEEP_WIDTH-1:0] keep);
        logic [BCW-1:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
            cnt = cnt + BCW'(keep[i]);
        end
        return cnt;
    endfunction

    // Thermometer keep: the lowest 'lanes' lanes set.
    function automatic logic [KEEP_WIDTH-1:0] therm_keep(input logic [BCW-1:0] lanes);
        logic [KEEP_WIDTH-1:0] mask;
        for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
            mask[i] = (i < 32'(lanes));
        end
        return mask;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] mask_data(input logic [DATA_WIDTH-1:0] data,
                                                        input logic [KEEP_WIDTH-1:0] keep);
        logic [DATA_WIDTH-1:0] out;
        for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
            out[8*i +: 8] = keep[i] ? data[8*i +: 8] : 8'h00;
        end
        return out;
    endfunction

    state_e                state_q, state_d;
    logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
    logic [BCW-1:0]        pad_left_q, pad_left_d;
    logic                  pad_en_q, pad_en_d;
    logic [USER_WIDTH-1:0] tuser_hold_q, tuser_hold_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic [USER_WIDTH-1:0] tuser_q, tuser_d;
    logic                  padded_q, padded_d;
    logic [CNT_WIDTH-1:0]  frame_count_q, frame_count_d;
    logic [CNT_WIDTH-1:0]  pad_count_q, pad_count_d;

    logic                  out_free;
    logic                  s_ready_c;
    logic                  accept;
    logic                  frame_pad;
    logic [BCW-1:0]        beat_bytes;
    logic [SUMW-1:0]       sum;
    logic [BCW-1:0]        total;
    logic [BCW-1:0]        need_lanes;

    // Next-state, output-register and statistics logic.
    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        pad_left_d    = pad_left_q;
        pad_en_d      = pad_en_q;
        tuser_hold_d  = tuser_hold_q;
        tdata_d       = tdata_q;
        tkeep_d       = tkeep_q;
        tvalid_d      = tvalid_q;
        tlast_d       = tlast_q;
        tuser_d       = tuser_q;
        padded_d      = padded_q;
        frame_count_d = frame_count_q;
        pad_count_d   = pad_count_q;

        out_free   = !tvalid_q || m_axis_tready;
        s_ready_c  = out_free && (state_q != PAD);
        accept     = s_axis_tvalid && s_ready_c;
        frame_pad  = (state_q == IDLE) ? pad_enable : pad_en_q;
        beat_bytes = popcount(s_axis_tkeep);
        sum        = SUMW'(byte_cnt_q) + SUMW'(beat_bytes);
        total      = (sum > SUMW'(SAT_B)) ? SAT_B : BCW'(sum);
        need_lanes = MIN_B - byte_cnt_q;

        if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
            if (tlast_q) begin
                frame_count_d = frame_count_q + CNT_WIDTH'(1);
                if (padded_q) begin
                    pad_count_d = pad_count_q + CNT_WIDTH'(1);
                end
            end
        end

        case (state_q)
            IDLE, BODY: begin
                if (accept) begin
                    tvalid_d = 1'b1;
                    tdata_d  = mask_data(s_axis_tdata, s_axis_tkeep);
                    tkeep_d  = s_axis_tkeep;
                    tlast_d  = s_axis_tlast;
                    tuser_d  = s_axis_tuser;
                    padded_d = 1'b0;
                    pad_en_d = frame_pad;
                    if (!s_axis_tlast) begin
                        byte_cnt_d = total;
                        state_d    = BODY;
                    end else begin
                        byte_cnt_d = '0;
                        state_d    = IDLE;
                        if (frame_pad && (total < MIN_B)) begin
                            if (need_lanes <= KEEP_B) begin
                                tkeep_d  = therm_keep(need_lanes);
                                padded_d = 1'b1;
                            end else begin
                                // Frame spills past this beat: hold tlast/tuser for the final pad beat.
                                tkeep_d      = '1;
                                tlast_d      = 1'b0;
                                tuser_d      = '0;
                                tuser_hold_d = s_axis_tuser;
                                pad_left_d   = need_lanes - KEEP_B;
                                state_d      = PAD;
                            end
                        end
                    end
                end
            end
            PAD: begin
                if (tvalid_q && tlast_q) begin
                    if (m_axis_tready) begin
                        state_d = IDLE;
                    end
                end else if (out_free) begin
                    tvalid_d = 1'b1;
                    tdata_d  = '0;
                    if (pad_left_q <= KEEP_B) begin
                        tkeep_d    = therm_keep(pad_left_q);
                        tlast_d    = 1'b1;
                        tuser_d    = tuser_hold_q;
                        padded_d   = 1'b1;
                        pad_left_d = '0;
                    end else begin
                        tkeep_d    = '1;
                        tlast_d    = 1'b0;
                        tuser_d    = '0;
                        padded_d   = 1'b0;
                        pad_left_d = pad_left_q - KEEP_B;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            byte_cnt_q    <= '0;
            pad_left_q    <= '0;
            pad_en_q      <= 1'b0;
            tuser_hold_q  <= '0;
            tdata_q       <= '0;
            tkeep_q       <= '0;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            tuser_q       <= '0;
            padded_q      <= 1'b0;
            frame_count_q <= '0;
            pad_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            pad_left_q    <= pad_left_d;
            pad_en_q      <= pad_en_d;
            tuser_hold_q  <= tuser_hold_d;
            tdata_q       <= tdata_d;
            tkeep_q       <= tkeep_d;
            tvalid_q      <= tvalid_d;
            tlast_q       <= tlast_d;
            tuser_q       <= tuser_d;
            padded_q      <= padded_d;
            frame_count_q <= frame_count_d;
            pad_count_q   <= pad_count_d;
        end
    end

    assign s_axis_tready = s_ready_c && !rst;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign frame_count   = frame_count_q;
    assign pad_count     = pad_count_q;

endmodule

// File: tb/tb_kugelblitz_pad_mask.sv
// Directed bench for kugelblitz_pad_mask at 512-bit and 64-bit widths, with a
// per-instance expected-beat queue and a backpressure soak on the 64-bit instance.
module tb_kugelblitz_pad_mask;

    typedef logic [639:0] cv_t;
    typedef struct packed {
        logic [511:0] data;
        logic [63:0]  keep;
        logic         last;
        logic         user;
    } beat_t;

    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [63:0]  s_d64;  logic [7:0]  s_k64;  logic s_v64, s_r64, s_l64; logic [0:0] s_u64;
    logic [63:0]  m_d64;  logic [7:0]  m_k64;  logic m_v64, m_l64;        logic [0:0] m_u64;
    logic         m_r64 = 1'b0;
    logic         pe64;
    logic [31:0]  fc64, pc64;

    logic [511:0] s_d512; logic [63:0] s_k512; logic s_v512, s_r512, s_l512; logic [0:0] s_u512;
    logic [511:0] m_d512; logic [63:0] m_k512; logic m_v512, m_l512;         logic [0:0] m_u512;
    logic         m_r512;
    logic         pe512;
    logic [31:0]  fc512, pc512;

    assign m_r512 = 1'b1;

    kugelblitz_pad_mask #(
        .DATA_WIDTH(64), .KEEP_WIDTH(8), .USER_WIDTH(1), .MIN_FRAME_LEN(60), .CNT_WIDTH(32)
    ) u_dut64 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_d64), .s_axis_tkeep(s_k64), .s_axis_tvalid(s_v64),
        .s_axis_tready(s_r64), .s_axis_tlast(s_l64), .s_axis_tuser(s_u64),
        .m_axis_tdata(m_d64), .m_axis_tkeep(m_k64), .m_axis_tvalid(m_v64),
        .m_axis_tready(m_r64), .m_axis_tlast(m_l64), .m_axis_tuser(m_u64),
        .pad_enable(pe64), .frame_count(fc64), .pad_count(pc64)
    );

    kugelblitz_pad_mask #(
        .DATA_WIDTH(512), .KEEP_WIDTH(64), .USER_WIDTH(1), .MIN_FRAME_LEN(60), .CNT_WIDTH(32)
    ) u_dut512 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_d512), .s_axis_tkeep(s_k512), .s_axis_tvalid(s_v512),
        .s_axis_tready(s_r512), .s_axis_tlast(s_l512), .s_axis_tuser(s_u512),
        .m_axis_tdata(m_d512), .m_axis_tkeep(m_k512), .m_axis_tvalid(m_v512),
        .m_axis_tready(m_r512), .m_axis_tlast(m_l512), .m_axis_tuser(m_u512),
        .pad_enable(pe512), .frame_count(fc512), .pad_count(pc512)
    );

    task automatic check(input string tag, input cv_t obs, input cv_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    beat_t exp64_q[$];
    beat_t exp512_q[$];
    int    exp_fc64;
    int    exp_pc64;

    // Egress ready pattern for the 64-bit instance: 0 low, 1 high, else ~30% low.
    int rdy_mode64 = 1;
    always @(posedge clk) begin
        #1;
        case (rdy_mode64)
            0:       m_r64 = 1'b0;
            1:       m_r64 = 1'b1;
            default: m_r64 = ($urandom_range(0, 99) >= 30);
        endcase
    end

    beat_t held64;
    logic  stall64 = 1'b0;
    always @(negedge clk) begin
        beat_t obs;
        beat_t e;
        obs      = '0;
        obs.data = 512'(m_d64);
        obs.keep = 64'(m_k64);
        obs.last = m_l64;
        obs.user = m_u64[0];
        if (stall64 && !rst) check("stable64", cv_t'(obs), cv_t'(held64));
        stall64 = m_v64 && !m_r64 && !rst;
        held64  = obs;
        if (m_v64 && m_r64 && !rst) begin
            if (exp64_q.size() == 0) begin
                check("beat64_pending", cv_t'(exp64_q.size()), cv_t'(1));
            end else begin
                e = exp64_q.pop_front();
                check("beat64", cv_t'(obs), cv_t'(e));
            end
        end
    end

    always @(negedge clk) begin
        beat_t obs;
        beat_t e;
        obs      = '0;
        obs.data = m_d512;
        obs.keep = m_k512;
        obs.last = m_l512;
        obs.user = m_u512[0];
        if (m_v512 && m_r512 && !rst) begin
            if (exp512_q.size() == 0) begin
                check("beat512_pending", cv_t'(exp512_q.size()), cv_t'(1));
            end else begin
                e = exp512_q.pop_front();
                check("beat512", cv_t'(obs), cv_t'(e));
            end
        end
    end

    task automatic push64(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
        beat_t e;
        e = '0; e.data = 512'(d); e.keep = 64'(k); e.last = l; e.user = u;
        exp64_q.push_back(e);
    endtask

    task automatic push512(input logic [511:0] d, input logic [63:0] k, input logic l, input logic u);
        beat_t e;
        e = '0; e.data = d; e.keep = k; e.last = l; e.user = u;
        exp512_q.push_back(e);
    endtask

    task automatic send64(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
        logic acc;
        acc = 1'b0;
        s_d64 = d; s_k64 = k; s_l64 = l; s_u64 = u; s_v64 = 1'b1;
        for (int i = 0; i < 1000 && !acc; i++) begin
            @(negedge clk);
            acc = s_r64;
            @(posedge clk);
            #1;
        end
        check("accept64", cv_t'(acc), cv_t'(1));
        s_v64 = 1'b0;
    endtask

    task automatic send512(input logic [511:0] d, input logic [63:0] k, input logic l, input logic u);
        logic acc;
        acc = 1'b0;
        s_d512 = d; s_k512 = k; s_l512 = l; s_u512 = u; s_v512 = 1'b1;
        for (int i = 0; i < 1000 && !acc; i++) begin
            @(negedge clk);
            acc = s_r512;
            @(posedge clk);
            #1;
        end
        check("accept512", cv_t'(acc), cv_t'(1));
        s_v512 = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && (exp64_q.size() != 0 || exp512_q.size() != 0); i++) begin
            @(posedge clk);
        end
        @(posedge clk);
        #1;
        check("drain", cv_t'(exp64_q.size() + exp512_q.size()), cv_t'(0));
    endtask

    // Contiguous frame of len bytes on the 64-bit instance; garbage above tkeep.
    task automatic run_frame64(input int len, input logic pad, input logic u, input logic toggle);
        logic [7:0]  b [0:127];
        logic [63:0] d;
        logic [7:0]  k;
        beat_t       e;
        int          total, nb, nbi, idx;
        for (int i = 0; i < 128; i++) b[i] = 8'($urandom);
        total = (pad && len < 60) ? 60 : len;
        nb    = (total + 7) / 8;
        nbi   = (len + 7) / 8;
        for (int x = 0; x < nb; x++) begin
            e = '0;
            for (int j = 0; j < 8; j++) begin
                idx = x * 8 + j;
                if (idx < total) e.keep[j] = 1'b1;
                if (idx < len)   e.data[8*j +: 8] = b[idx];
            end
            e.last = (x == nb - 1);
            e.user = e.last ? u : 1'b0;
            exp64_q.push_back(e);
        end
        exp_fc64++;
        if (pad && len < 60) exp_pc64++;
        pe64 = pad;
        for (int x = 0; x < nbi; x++) begin
            for (int j = 0; j < 8; j++) begin
                idx = x * 8 + j;
                k[j] = (idx < len);
                d[8*j +: 8] = (idx < len) ? b[idx] : 8'($urandom);
            end
            send64(d, k, (x == nbi - 1), (x == nbi - 1) ? u : 1'b0);
            if (toggle) pe64 = 1'($urandom);
        end
    endtask

    logic [511:0] d_a, d_b, e_a, e_b;
    int           len_r;
    logic         pad_r, usr_r;

    initial begin
        rst = 1'b1;
        s_d64 = '0; s_k64 = '0; s_v64 = 1'b0; s_l64 = 1'b0; s_u64 = '0; pe64 = 1'b0;
        s_d512 = '0; s_k512 = '0; s_v512 = 1'b0; s_l512 = 1'b0; s_u512 = '0; pe512 = 1'b0;
        exp_fc64 = 0; exp_pc64 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_tready64", cv_t'(s_r64), cv_t'(0));
        check("rst_s_tready512", cv_t'(s_r512), cv_t'(0));
        check("rst_m_tvalid64", cv_t'(m_v64), cv_t'(0));
        check("rst_m_tlast64", cv_t'(m_l64), cv_t'(0));
        check("rst_m_tdata64", cv_t'(m_d64), cv_t'(0));
        check("rst_m_tkeep64", cv_t'(m_k64), cv_t'(0));
        check("rst_m_tvalid512", cv_t'(m_v512), cv_t'(0));
        check("rst_counts64", cv_t'({fc64, pc64}), cv_t'(0));
        check("rst_counts512", cv_t'({fc512, pc512}), cv_t'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 14-byte frame, padding on: one beat widened to 60 lanes, bytes 14..59 zero.
        for (int j = 0; j < 64; j++) begin
            d_a[8*j +: 8] = (j < 14) ? 8'(j + 1) : 8'hA5;
            e_a[8*j +: 8] = (j < 14) ? 8'(j + 1) : 8'h00;
        end
        pe512 = 1'b1;
        push512(e_a, 64'h0FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        send512(d_a, 64'h0000_0000_0000_3FFF, 1'b1, 1'b1);
        drain(200);
        check("fc512_a", cv_t'(fc512), cv_t'(1));
        check("pc512_a", cv_t'(pc512), cv_t'(1));

        // Same frame with padding off: passes with original keep.
        pe512 = 1'b0;
        push512(e_a, 64'h0000_0000_0000_3FFF, 1'b1, 1'b0);
        send512(d_a, 64'h0000_0000_0000_3FFF, 1'b1, 1'b0);
        drain(200);
        check("fc512_b", cv_t'(fc512), cv_t'(2));
        check("pc512_b", cv_t'(pc512), cv_t'(1));

        // 64-byte frame over two partial beats with garbage in masked lanes.
        for (int j = 0; j < 64; j++) begin
            d_a[8*j +: 8] = 8'(j * 3 + 7);
            d_b[8*j +: 8] = 8'(8'hF0 ^ 8'(j));
            e_a[8*j +: 8] = (j < 48) ? 8'(j * 3 + 7) : 8'h00;
            e_b[8*j +: 8] = (j < 16) ? 8'(8'hF0 ^ 8'(j)) : 8'h00;
        end
        pe512 = 1'b1;
        push512(e_a, 64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        push512(e_b, 64'h0000_0000_0000_FFFF, 1'b1, 1'b1);
        send512(d_a, 64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        send512(d_b, 64'h0000_0000_0000_FFFF, 1'b1, 1'b1);
        drain(200);
        check("fc512_c", cv_t'(fc512), cv_t'(3));
        check("pc512_c", cv_t'(pc512), cv_t'(1));

        // 59-byte frame: widened by exactly one lane, which must be zero.
        for (int j = 0; j < 64; j++) begin
            d_a[8*j +: 8] = (j < 59) ? 8'(j + 100) : 8'hEE;
            e_a[8*j +: 8] = (j < 59) ? 8'(j + 100) : 8'h00;
        end
        push512(e_a, 64'h0FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        send512(d_a, 64'h07FF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        drain(200);
        check("fc512_d", cv_t'(fc512), cv_t'(4));
        check("pc512_d", cv_t'(pc512), cv_t'(2));

        // 64-bit: 20-byte frame padded to 8 beats, tlast/tuser on beat 8 only.
        pe64 = 1'b1;
        push64(64'h0807_0605_0403_0201, 8'hFF, 1'b0, 1'b0);
        push64(64'h100F_0E0D_0C0B_0A09, 8'hFF, 1'b0, 1'b0);
        push64(64'h0000_0000_1413_1211, 8'hFF, 1'b0, 1'b0);
        for (int x = 0; x < 4; x++) push64(64'h0, 8'hFF, 1'b0, 1'b0);
        push64(64'h0, 8'h0F, 1'b1, 1'b1);
        send64(64'h0807_0605_0403_0201, 8'hFF, 1'b0, 1'b0);
        send64(64'h100F_0E0D_0C0B_0A09, 8'hFF, 1'b0, 1'b0);
        send64(64'hDEAD_BEEF_1413_1211, 8'h0F, 1'b1, 1'b1);
        drain(200);
        check("fc64_a", cv_t'(fc64), cv_t'(1));
        check("pc64_a", cv_t'(pc64), cv_t'(1));

        // pad_enable raised mid-frame only applies from the next frame.
        pe64 = 1'b0;
        push64(64'h8877_6655_4433_2211, 8'hFF, 1'b0, 1'b0);
        push64(64'h0000_0000_CCBB_AA99, 8'h0F, 1'b1, 1'b0);
        send64(64'h8877_6655_4433_2211, 8'hFF, 1'b0, 1'b0);
        pe64 = 1'b1;
        send64(64'h1234_5678_CCBB_AA99, 8'h0F, 1'b1, 1'b0);
        drain(200);
        check("fc64_b", cv_t'(fc64), cv_t'(2));
        check("pc64_b", cv_t'(pc64), cv_t'(1));

        exp_fc64 = 2;
        exp_pc64 = 1;
        run_frame64(59, 1'b1, 1'b1, 1'b0);
        run_frame64(60, 1'b1, 1'b0, 1'b0);
        run_frame64(61, 1'b1, 1'b1, 1'b0);
        run_frame64(7,  1'b0, 1'b1, 1'b0);
        run_frame64(1,  1'b1, 1'b0, 1'b0);
        drain(500);
        check("fc64_c", cv_t'(fc64), cv_t'(exp_fc64));
        check("pc64_c", cv_t'(pc64), cv_t'(exp_pc64));

        // Reset while in PAD with egress stalled: frame dropped, counters cleared.
        rdy_mode64 = 0;
        @(posedge clk);
        #2;
        pe64 = 1'b1;
        send64(64'h0102_0304_0506_0708, 8'hFF, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("pad_stalled_tvalid64", cv_t'(m_v64), cv_t'(1));
        check("pad_stalled_tready64", cv_t'(s_r64), cv_t'(0));
        rst = 1'b1;
        @(negedge clk);
        check("rst_pad_s_tready64", cv_t'(s_r64), cv_t'(0));
        @(posedge clk);
        #1;
        check("rst_pad_tvalid64", cv_t'(m_v64), cv_t'(0));
        check("rst_pad_counts64", cv_t'({fc64, pc64}), cv_t'(0));
        rst = 1'b0;
        rdy_mode64 = 1;
        exp_fc64 = 0;
        exp_pc64 = 0;
        @(posedge clk);
        #2;
        run_frame64(20, 1'b1, 1'b1, 1'b0);
        drain(200);
        check("fc64_d", cv_t'(fc64), cv_t'(1));
        check("pc64_d", cv_t'(pc64), cv_t'(1));

        // Backpressure soak with random lengths, padding and mid-frame pad_enable noise.
        rdy_mode64 = 2;
        for (int f = 0; f < 1000; f++) begin
            len_r = $urandom_range(1, 100);
            pad_r = 1'($urandom);
            usr_r = 1'($urandom);
            run_frame64(len_r, pad_r, usr_r, 1'b1);
        end
        drain(3000);
        check("fc64_soak", cv_t'(fc64), cv_t'(exp_fc64));
        check("pc64_soak", cv_t'(pc64), cv_t'(exp_pc64));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
